// File: rtl/ark_rr_arbiter_if.sv
// ark_rr_arbiter_if: two requester channels plus one tagged result stream
// for the shared AddRoundKey stage.
interface ark_rr_arbiter_if #(
  parameter int WIDTH = 128
);
  logic             v0_i;
  logic [WIDTH-1:0] state0_i;
  logic [WIDTH-1:0] key0_i;
  logic             ready0_o;
  logic             v1_i;
  logic [WIDTH-1:0] state1_i;
  logic [WIDTH-1:0] key1_i;
  logic             ready1_o;
  logic             v_o;
  logic [WIDTH-1:0] result_o;
  logic             id_o;
  logic             ready_i;

  modport master (
    output v0_i, state0_i, key0_i,
    output v1_i, state1_i, key1_i,
    output ready_i,
    input  ready0_o, ready1_o,
    input  v_o, result_o, id_o
  );

  modport slave (
    input  v0_i, state0_i, key0_i,
    input  v1_i, state1_i, key1_i,
    input  ready_i,
    output ready0_o, ready1_o,
    output v_o, result_o, id_o
  );
endinterface

// File: rtl/ark_rr_arbiter.sv
// ark_rr_arbiter: round-robin share of one state^key stage, 1-entry output.
// Optional saturating grant counters: define ARK_ARB_STATS_EN.
module ark_rr_arbiter #(
  parameter int WIDTH = 128,
  parameter int CNT_W = 16
) (
  input  logic            clk_i,
  input  logic            reset_n_i,
  ark_rr_arbiter_if.slave bus
`ifdef ARK_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] grant_cnt0_o,
  output logic [CNT_W-1:0] grant_cnt1_o
`endif
);

  logic             r_v;
  logic [WIDTH-1:0] r_res;
  logic             r_id;
  logic             r_last;

  logic             w_free;
  logic             w_g0;
  logic             w_g1;
  logic [WIDTH-1:0] w_data;

  assign w_free = !r_v | bus.ready_i;

  // Round-robin grant; a tie goes to the channel not served last.
  always_comb begin
    w_g0 = 1'b0;
    w_g1 = 1'b0;
    if (reset_n_i && w_free) begin
      unique case (1'b1)
        (bus.v0_i & bus.v1_i): begin
          w_g0 = r_last;
          w_g1 = !r_last;
        end
        (bus.v0_i & !bus.v1_i): w_g0 = 1'b1;
        (!bus.v0_i & bus.v1_i): w_g1 = 1'b1;
        default: ;
      endcase
    end
  end

  // Single shared XOR, operands picked by the grant.
  always_comb begin
    w_data = bus.state0_i ^ bus.key0_i;
    if (w_g1) begin
      w_data = bus.state1_i ^ bus.key1_i;
    end
  end

  // Output slot: load on grant, drain on accept, hold otherwise.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_v    <= 1'b0;
      r_res  <= '0;
      r_id   <= 1'b0;
      r_last <= 1'b1;
    end else if (w_g0 | w_g1) begin
      r_v    <= 1'b1;
      r_res  <= w_data;
      r_id   <= w_g1;
      r_last <= w_g1;
    end else if (bus.ready_i) begin
      r_v    <= 1'b0;
    end
  end

  assign bus.ready0_o = w_g0;
  assign bus.ready1_o = w_g1;
  assign bus.v_o      = r_v;
  assign bus.result_o = r_res;
  assign bus.id_o     = r_id;

`ifdef ARK_ARB_STATS_EN
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  // Per-channel grant counters, saturating at all-ones.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_g0 && (r_cnt0 != '1)) begin
        r_cnt0 <= r_cnt0 + CNT_W'(1);
      end
      if (w_g1 && (r_cnt1 != '1)) begin
        r_cnt1 <= r_cnt1 + CNT_W'(1);
      end
    end
  end

  assign grant_cnt0_o = r_cnt0;
  assign grant_cnt1_o = r_cnt1;
`endif

endmodule

// File: tb/tb_ark_rr_arbiter.sv
// tb_ark_rr_arbiter: directed and random checks of ark_rr_arbiter
// against a queue-based reference model.
module tb_ark_rr_arbiter;
  localparam int W = 128;
`ifdef ARK_ARB_STATS_EN
  localparam int CW = 2;
`else
  localparam int CW = 16;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ark_rr_arbiter_if #(.WIDTH(W)) bus ();

`ifdef ARK_ARB_STATS_EN
  logic [CW-1:0] cnt0;
  logic [CW-1:0] cnt1;
`endif

  ark_rr_arbiter #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk_i(clk),
    .reset_n_i(rst_n),
    .bus(bus)
`ifdef ARK_ARB_STATS_EN
    ,
    .grant_cnt0_o(cnt0),
    .grant_cnt1_o(cnt1)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: pending results queue, last served channel,
  // and the last loaded {id,result} (what the output must show).
  logic [W:0] m_q[$];
  int         m_last = 1;
  logic [W:0] m_hold = '0;
  int         g_prev = 0;

  function automatic logic [W-1:0] rnd();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // 0: no grant, 1: channel 0, 2: channel 1
  function automatic int pred();
    bit free;
    free = (m_q.size() == 0) || (bus.ready_i == 1'b1);
    if (!rst_n || !free) return 0;
    if (bus.v0_i && bus.v1_i) return (m_last == 1) ? 1 : 2;
    if (bus.v0_i) return 1;
    if (bus.v1_i) return 2;
    return 0;
  endfunction

  task automatic tick();
    int g;
    logic [W-1:0] d0;
    logic [W-1:0] d1;
    g  = pred();
    d0 = bus.state0_i ^ bus.key0_i;
    d1 = bus.state1_i ^ bus.key1_i;
    @(posedge clk);
    if (!rst_n) begin
      m_q.delete();
      m_last = 1;
      m_hold = '0;
    end else begin
      if (bus.ready_i && m_q.size() > 0) void'(m_q.pop_front());
      if (g == 1) begin
        m_q.push_back({1'b0, d0});
        m_hold = {1'b0, d0};
        m_last = 0;
      end else if (g == 2) begin
        m_q.push_back({1'b1, d1});
        m_hold = {1'b1, d1};
        m_last = 1;
      end
    end
    g_prev = g;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.v0_i = 1'b1;
    bus.v1_i = 1'b1;
    bus.ready_i = 1'b1;
    #1;
    checks++;
    if ({bus.ready0_o, bus.ready1_o} !== 2'b00) begin
      errors++;
      $display("FAIL reset_rdy: got %b want 00",
               {bus.ready0_o, bus.ready1_o});
    end
    tick();
    bus.v0_i = 1'b0;
    bus.v1_i = 1'b0;
    #1;
    checks++;
    if ({bus.v_o, bus.id_o, bus.result_o} !== {2'b00, {W{1'b0}}}) begin
      errors++;
      $display("FAIL reset_out: got v=%b id=%b r=%h want 0/0/0",
               bus.v_o, bus.id_o, bus.result_o);
    end
`ifdef ARK_ARB_STATS_EN
    checks++;
    if ({cnt0, cnt1} !== '0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d/%0d want 0/0", cnt0, cnt1);
    end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic [W-1:0] exp;
    exp = 128'h00102030405060708090a0b0c0d0e0f0;
    bus.v0_i = 1'b1;
    bus.state0_i = 128'h00112233445566778899aabbccddeeff;
    bus.key0_i = 128'h000102030405060708090a0b0c0d0e0f;
    bus.v1_i = 1'b0;
    bus.ready_i = 1'b1;
    #1;
    checks++;
    if ({bus.ready0_o, bus.ready1_o} !== 2'b10) begin
      errors++;
      $display("FAIL single_rdy: got %b want 10",
               {bus.ready0_o, bus.ready1_o});
    end
    tick();
    bus.v0_i = 1'b0;
    #1;
    checks++;
    if ({bus.v_o, bus.id_o, bus.result_o} !== {2'b10, exp}) begin
      errors++;
      $display("FAIL single_out: got v=%b id=%b r=%h want 1/0/%h",
               bus.v_o, bus.id_o, bus.result_o, exp);
    end
    tick();
  endtask

  task automatic test_fairness();
    logic [W:0] prev;
    logic [1:0] exp;
    prev = '0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.ready_i = 1'b1;
    bus.v0_i = 1'b1;
    bus.v1_i = 1'b1;
    bus.state0_i = rnd();
    bus.key0_i = rnd();
    bus.state1_i = rnd();
    bus.key1_i = rnd();
    for (int i = 0; i < 4; i++) begin
      #1;
      exp = (i % 2 == 0) ? 2'b10 : 2'b01;
      checks++;
      if ({bus.ready0_o, bus.ready1_o} !== exp) begin
        errors++;
        $display("FAIL fair_rdy%0d: got %b want %b", i,
                 {bus.ready0_o, bus.ready1_o}, exp);
      end
      if (i > 0) begin
        checks++;
        if ({bus.v_o, bus.id_o, bus.result_o} !== {1'b1, prev}) begin
          errors++;
          $display("FAIL fair_out%0d: got %b/%b/%h want 1/%b/%h", i,
                   bus.v_o, bus.id_o, bus.result_o, prev[W], prev[W-1:0]);
        end
      end
      prev = (i % 2 == 0) ? {1'b0, bus.state0_i ^ bus.key0_i}
                          : {1'b1, bus.state1_i ^ bus.key1_i};
      tick();
      if (i % 2 == 0) begin
        bus.state0_i = rnd();
        bus.key0_i = rnd();
      end else begin
        bus.state1_i = rnd();
        bus.key1_i = rnd();
      end
    end
    bus.v0_i = 1'b0;
    bus.v1_i = 1'b0;
    #1;
    checks++;
    if ({bus.v_o, bus.id_o, bus.result_o} !== {1'b1, prev}) begin
      errors++;
      $display("FAIL fair_last: got %b/%b/%h want 1/%b/%h",
               bus.v_o, bus.id_o, bus.result_o, prev[W], prev[W-1:0]);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a;
    logic [W-1:0] b;
    bus.ready_i = 1'b1;
    bus.v0_i = 1'b1;
    bus.state0_i = rnd();
    bus.key0_i = rnd();
    a = bus.state0_i ^ bus.key0_i;
    tick();
    bus.v0_i = 1'b0;
    bus.ready_i = 1'b0;
    bus.v1_i = 1'b1;
    bus.state1_i = rnd();
    bus.key1_i = rnd();
    b = bus.state1_i ^ bus.key1_i;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({bus.ready0_o, bus.ready1_o, bus.v_o, bus.id_o, bus.result_o}
          !== {4'b0010, a}) begin
        errors++;
        $display("FAIL bp_stall%0d: got rdy=%b v=%b id=%b r=%h want 00/1/0/%h",
                 i, {bus.ready0_o, bus.ready1_o}, bus.v_o, bus.id_o,
                 bus.result_o, a);
      end
      tick();
    end
    bus.ready_i = 1'b1;
    #1;
    checks++;
    if ({bus.ready0_o, bus.ready1_o, bus.v_o, bus.id_o, bus.result_o}
        !== {4'b0110, a}) begin
      errors++;
      $display("FAIL bp_drain: got rdy=%b v=%b id=%b r=%h want 01/1/0/%h",
               {bus.ready0_o, bus.ready1_o}, bus.v_o, bus.id_o,
               bus.result_o, a);
    end
    tick();
    bus.v1_i = 1'b0;
    #1;
    checks++;
    if ({bus.v_o, bus.id_o, bus.result_o} !== {2'b11, b}) begin
      errors++;
      $display("FAIL bp_new: got %b/%b/%h want 1/1/%h",
               bus.v_o, bus.id_o, bus.result_o, b);
    end
    tick();
    #1;
    checks++;
    if ({bus.v_o, bus.id_o, bus.result_o} !== {2'b01, b}) begin
      errors++;
      $display("FAIL bp_idle: got %b/%b/%h want 0/1/%h",
               bus.v_o, bus.id_o, bus.result_o, b);
    end
  endtask

  task automatic test_patterns();
    logic [W-1:0] a5;
    a5 = {(W/8){8'ha5}};
    bus.ready_i = 1'b1;
    bus.v0_i = 1'b1;
    bus.state0_i = {W{1'b1}};
    bus.key0_i = {W{1'b1}};
    tick();
    bus.v0_i = 1'b0;
    bus.v1_i = 1'b1;
    bus.state1_i = '0;
    bus.key1_i = a5;
    #1;
    checks++;
    if ({bus.v_o, bus.id_o, bus.result_o} !== {2'b10, {W{1'b0}}}) begin
      errors++;
      $display("FAIL pat_ones: got %b/%b/%h want 1/0/0",
               bus.v_o, bus.id_o, bus.result_o);
    end
    tick();
    bus.v1_i = 1'b0;
    #1;
    checks++;
    if ({bus.v_o, bus.id_o, bus.result_o} !== {2'b11, a5}) begin
      errors++;
      $display("FAIL pat_a5: got %b/%b/%h want 1/1/%h",
               bus.v_o, bus.id_o, bus.result_o, a5);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bus.ready_i = 1'b0;
    bus.v0_i = 1'b1;
    bus.state0_i = rnd();
    bus.key0_i = rnd();
    tick();
    bus.v1_i = 1'b1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.ready0_o, bus.ready1_o, bus.v_o} !== 3'b001) begin
      errors++;
      $display("FAIL rmid_low: got rdy=%b v=%b want 00/1",
               {bus.ready0_o, bus.ready1_o}, bus.v_o);
    end
    tick();
    #1;
    checks++;
    if ({bus.v_o, bus.id_o, bus.result_o} !== {2'b00, {W{1'b0}}}) begin
      errors++;
      $display("FAIL rmid_out: got %b/%b/%h want 0/0/0",
               bus.v_o, bus.id_o, bus.result_o);
    end
    rst_n = 1'b1;
    bus.ready_i = 1'b1;
    #1;
    checks++;
    if ({bus.ready0_o, bus.ready1_o} !== 2'b10) begin
      errors++;
      $display("FAIL rmid_tie: got %b want 10",
               {bus.ready0_o, bus.ready1_o});
    end
    tick();
    bus.v0_i = 1'b0;
    bus.v1_i = 1'b0;
    tick();
  endtask

  task automatic test_random();
    int g;
    for (int i = 0; i < 2000; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      bus.ready_i = ($urandom_range(0, 3) != 0);
      if (!bus.v0_i || g_prev == 1) begin
        bus.v0_i = ($urandom_range(0, 2) != 0);
        bus.state0_i = rnd();
        bus.key0_i = ($urandom_range(0, 7) == 0) ? bus.state0_i : rnd();
      end
      if (!bus.v1_i || g_prev == 2) begin
        bus.v1_i = ($urandom_range(0, 2) != 0);
        bus.state1_i = rnd();
        bus.key1_i = rnd();
      end
      #1;
      g = pred();
      checks++;
      if ({bus.ready0_o, bus.ready1_o} !== {g == 1, g == 2}) begin
        errors++;
        $display("FAIL rnd_rdy@%0d: got %b want %b", i,
                 {bus.ready0_o, bus.ready1_o}, {g == 1, g == 2});
      end
      checks++;
      if ({bus.v_o, bus.id_o, bus.result_o} !== {m_q.size() > 0, m_hold}) begin
        errors++;
        $display("FAIL rnd_out@%0d: got %b/%b/%h want %b/%b/%h", i,
                 bus.v_o, bus.id_o, bus.result_o, m_q.size() > 0,
                 m_hold[W], m_hold[W-1:0]);
      end
      tick();
    end
    rst_n = 1'b1;
    bus.v0_i = 1'b0;
    bus.v1_i = 1'b0;
    bus.ready_i = 1'b1;
    tick();
  endtask

`ifdef ARK_ARB_STATS_EN
  task automatic test_stats();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.ready_i = 1'b1;
    bus.v1_i = 1'b0;
    bus.v0_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.state0_i = rnd();
      bus.key0_i = rnd();
      tick();
    end
    bus.v0_i = 1'b0;
    #1;
    checks++;
    if ({cnt0, cnt1} !== {2'd3, 2'd0}) begin
      errors++;
      $display("FAIL stats_sat: got %0d/%0d want 3/0", cnt0, cnt1);
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    bus.v0_i = 1'b0;
    bus.v1_i = 1'b0;
    bus.state0_i = '0;
    bus.key0_i = '0;
    bus.state1_i = '0;
    bus.key1_i = '0;
    bus.ready_i = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_patterns();
    test_reset_mid();
    test_random();
`ifdef ARK_ARB_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
